// File: rtl/pwm_input_capture_pkg.sv
// Shared definitions for the PWM capture path: state encodings and default counter width.
// The PWM generator imports the same package, so keep encodings stable.
package pwm_input_capture_pkg;

  localparam int PWM_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM input into the clock domain, applies polarity and flags edges.
// Latency: a level first sampled at edge N shows up as rise/fall in the cycle after edge N+1.
module pwm_edge_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic pwm_i,
  input  logic pol_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic dly_q;
  logic lvl_d;

  // Polarity is applied after the synchronizer so the metastability chain never sees it.
  assign lvl_d = sync2_q ^ pol_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      dly_q   <= lvl_d;
    end
  end

  assign rise_o = lvl_d & ~dly_q;
  assign fall_o = ~lvl_d & dly_q;

endmodule

// File: rtl/pwm_input_capture.sv
// Measures PWM period and active-phase length in prescaler ticks; one-clock strobe per capture.
// Counter saturation aborts the measurement, re-arms, and sets a sticky overflow flag.
module pwm_input_capture
  import pwm_input_capture_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH_DEF
) (
  input  logic             clk_psc_i,
  input  logic             rst_n_i,
  input  logic             cen_i,
  input  logic             ck_cnt_i,
  input  logic             pwm_in_i,
  input  logic             pol_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] period_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             capture_valid_o,
  output logic             overflow_o
);

  cap_state_e       state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] high_q;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] duty_q;
  logic             valid_q;
  logic             ovf_q;

  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] snap_d;
  logic             measuring_d;
  logic             sat_d;

  pwm_edge_sync u_edge_sync (
    .clk_i   (clk_psc_i),
    .rst_n_i (rst_n_i),
    .pwm_i   (pwm_in_i),
    .pol_i   (pol_i),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  // A tick landing in the edge cycle is credited to the measurement that is ending.
  assign snap_d      = cnt_q + WIDTH'(ck_cnt_i);
  assign measuring_d = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign sat_d       = measuring_d && ck_cnt_i && (cnt_q == {WIDTH{1'b1}});

  always_ff @(posedge clk_psc_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      high_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (!cen_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else if (sat_d) begin
        // Abort wins over any coincident edge; a fresh rise is needed to restart.
        ovf_q   <= 1'b1;
        cnt_q   <= '0;
        state_q <= ST_ARM;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q   <= '0;
            state_q <= ST_ARM;
          end
          ST_ARM: begin
            cnt_q <= '0;
            if (rise) begin
              state_q <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            cnt_q <= snap_d;
            if (fall) begin
              high_q  <= snap_d;
              state_q <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (rise) begin
              period_q <= snap_d;
              duty_q   <= high_q;
              valid_q  <= 1'b1;
              cnt_q    <= '0;
              state_q  <= ST_HIGH;
            end else begin
              cnt_q <= snap_d;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign period_o        = period_q;
  assign duty_o          = duty_q;
  assign capture_valid_o = valid_q;
  assign overflow_o      = ovf_q;

endmodule

// File: tb/tb_pwm_input_capture.sv
// Drives a 16-bit and an 8-bit capture block with the same waveform and checks both every cycle
// against a tick-counting reference model, plus directed expectations from the waveform shapes.
module tb_pwm_input_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        ck_cnt = 1'b0;
  logic        pwm_in = 1'b0;
  logic        pol = 1'b0;
  logic        ovf_clr = 1'b0;

  logic [15:0] p16, d16;
  logic        v16, o16;
  logic [7:0]  p8, d8;
  logic        v8, o8;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int vcnt16 = 0;
  int vcnt8  = 0;

  // Reference model state, index 0 = 16-bit block, 1 = 8-bit block.
  // mode: 0 idle, 1 armed, 2 measuring active phase, 3 measuring inactive phase.
  int m_mode [2];
  int m_ticks[2];
  int m_high [2];
  int m_per  [2];
  int m_duty [2];
  bit m_vld  [2];
  bit m_ovf  [2];
  int m_max  [2] = '{65535, 255};
  // Conditioned input as sampled at the previous three edges.
  bit h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  always #5 clk = ~clk;

  pwm_input_capture #(.WIDTH(16)) dut16 (
    .clk_psc_i(clk), .rst_n_i(rst_n), .cen_i(cen), .ck_cnt_i(ck_cnt), .pwm_in_i(pwm_in),
    .pol_i(pol), .ovf_clr_i(ovf_clr), .period_o(p16), .duty_o(d16),
    .capture_valid_o(v16), .overflow_o(o16)
  );

  pwm_input_capture #(.WIDTH(8)) dut8 (
    .clk_psc_i(clk), .rst_n_i(rst_n), .cen_i(cen), .ck_cnt_i(ck_cnt), .pwm_in_i(pwm_in),
    .pol_i(pol), .ovf_clr_i(ovf_clr), .period_o(p8), .duty_o(d8),
    .capture_valid_o(v8), .overflow_o(o8)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edges are acted on two clocks after the input is first sampled; ticks are plain integers.
  task automatic model_step();
    bit rise, fall;
    int t;
    rise = h2 & ~h3;
    fall = ~h2 & h3;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_mode[i] = 0; m_ticks[i] = 0; m_high[i] = 0;
        m_per[i] = 0; m_duty[i] = 0; m_vld[i] = 1'b0; m_ovf[i] = 1'b0;
      end else begin
        m_vld[i] = 1'b0;
        if (ovf_clr) m_ovf[i] = 1'b0;
        if (!cen) begin
          m_mode[i] = 0; m_ticks[i] = 0;
        end else if (m_mode[i] == 0) begin
          m_mode[i] = 1;
        end else if (m_mode[i] == 1) begin
          if (rise) begin m_mode[i] = 2; m_ticks[i] = 0; end
        end else begin
          t = m_ticks[i] + int'(ck_cnt);
          if (t > m_max[i]) begin
            m_ovf[i] = 1'b1; m_mode[i] = 1; m_ticks[i] = 0;
          end else if (m_mode[i] == 2 && fall) begin
            m_high[i] = t; m_mode[i] = 3; m_ticks[i] = t;
          end else if (m_mode[i] == 3 && rise) begin
            m_per[i] = t; m_duty[i] = m_high[i]; m_vld[i] = 1'b1;
            m_ticks[i] = 0; m_mode[i] = 2;
          end else begin
            m_ticks[i] = t;
          end
        end
      end
    end
    if (!rst_n) begin
      h1 = pol; h2 = pol; h3 = 1'b0;
    end else begin
      h3 = h2; h2 = h1; h1 = pwm_in ^ pol;
    end
  endtask

  task automatic cyc(input logic p, input logic c);
    @(negedge clk);
    pwm_in = p;
    ck_cnt = c;
    @(posedge clk);
    model_step();
    gcyc++;
    #1;
    if (v16) vcnt16++;
    if (v8)  vcnt8++;
    chk("period16", p16, 16'(m_per[0]));
    chk("duty16",   d16, 16'(m_duty[0]));
    chk("valid16",  {15'd0, v16}, {15'd0, m_vld[0]});
    chk("ovf16",    {15'd0, o16}, {15'd0, m_ovf[0]});
    chk("period8",  {8'd0, p8}, 16'(m_per[1]));
    chk("duty8",    {8'd0, d8}, 16'(m_duty[1]));
    chk("valid8",   {15'd0, v8}, {15'd0, m_vld[1]});
    chk("ovf8",     {15'd0, o8}, {15'd0, m_ovf[1]});
  endtask

  // ck_div 0 means a tick every clock, otherwise one tick every ck_div clocks.
  task automatic wave(input int hi, input int lo, input int ck_div);
    for (int k = 0; k < hi + lo; k++)
      cyc(k < hi, (ck_div == 0) ? 1'b1 : ((gcyc % ck_div) == 0));
  endtask

  task automatic reconfig(input logic new_pol);
    cen = 1'b0;
    pol = new_pol;
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
    cen = 1'b1;
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
  endtask

  initial begin
    // Reset state
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
    chk("rst_period", p16, 16'd0);
    chk("rst_duty", d16, 16'd0);
    chk("rst_valid", {15'd0, v16}, 16'd0);
    chk("rst_ovf", {15'd0, o16}, 16'd0);
    rst_n = 1'b1;

    // 10-clock period, 3 high, tick every clock: first rise only arms
    reconfig(1'b0);
    vcnt16 = 0;
    for (int k = 0; k < 6; k++) wave(3, 7, 0);
    chk("basic_captures", 16'(vcnt16), 16'd5);
    chk("basic_period", p16, 16'd10);
    chk("basic_duty", d16, 16'd3);
    chk("basic_period8", {8'd0, p8}, 16'd10);

    // Tick every 4th clock, 40-clock period with 12 high
    for (int k = 0; k < 4; k++) wave(12, 28, 4);
    chk("psc_period", p16, 16'd10);
    chk("psc_duty", d16, 16'd3);

    // Inverted polarity measures the low phase
    reconfig(1'b1);
    for (int k = 0; k < 4; k++) wave(3, 7, 0);
    chk("pol_period", p16, 16'd10);
    chk("pol_duty", d16, 16'd7);

    // Long high phase saturates only the 8-bit block
    reconfig(1'b0);
    for (int k = 0; k < 3; k++) wave(3, 7, 0);
    for (int k = 0; k < 300; k++) cyc(1'b1, 1'b1);
    chk("sat_ovf8", {15'd0, o8}, 16'd1);
    chk("sat_ovf16", {15'd0, o16}, 16'd0);
    for (int k = 0; k < 4; k++) wave(3, 7, 0);
    chk("sat_resume_period8", {8'd0, p8}, 16'd10);
    chk("sat_resume_duty8", {8'd0, d8}, 16'd3);
    chk("sat_sticky8", {15'd0, o8}, 16'd1);
    ovf_clr = 1'b1;
    cyc(1'b0, 1'b1);
    ovf_clr = 1'b0;
    chk("ovf_cleared8", {15'd0, o8}, 16'd0);

    // Disable in the middle of the low phase
    for (int k = 0; k < 2; k++) wave(3, 7, 0);
    wave(3, 3, 0);
    vcnt16 = 0;
    cen = 1'b0;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    cen = 1'b1;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    wave(3, 7, 0);
    chk("cen_no_capture", 16'(vcnt16), 16'd0);
    chk("cen_held_period", p16, 16'd10);
    chk("cen_held_duty", d16, 16'd3);
    wave(3, 7, 0);
    chk("cen_resume_captures", 16'(vcnt16), 16'd1);

    // One-clock reset during the low phase
    wave(3, 4, 0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1);
    rst_n = 1'b1;
    chk("mid_rst_period", p16, 16'd0);
    chk("mid_rst_duty", d16, 16'd0);
    vcnt16 = 0;
    cyc(1'b0, 1'b1); cyc(1'b0, 1'b1);
    wave(3, 7, 0);
    chk("mid_rst_no_capture", 16'(vcnt16), 16'd0);
    wave(3, 7, 0);
    chk("mid_rst_period_after", p16, 16'd10);

    // Randomized phases, tick density, clears, disables and polarity
    for (int n = 0; n < 150; n++) begin
      int hi, lo, dens;
      hi   = $urandom_range(2, 20);
      lo   = $urandom_range(2, 20);
      dens = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) reconfig(1'($urandom_range(0, 1)));
      ovf_clr = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < hi + lo; k++) begin
        cyc(k < hi, (dens == 0) ? 1'b1 : ($urandom_range(0, dens) != 0));
        ovf_clr = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
